// File: rtl/memory_arbiter.sv
// Round-robin arbiter that serialises CLIENTS requesters onto one single-port memory.
// Each op walks IDLE -> ACCESS -> DONE -> ACK and answers with a one-cycle ack pulse.
module memory_arbiter #(
  parameter int CLIENTS = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CLIENTS-1:0]         req,
  input  logic [CLIENTS-1:0]         we,
  input  logic [CLIENTS*ADDR_W-1:0]  addr,
  input  logic [CLIENTS*DATA_W-1:0]  wdata,
  output logic [CLIENTS-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ACK
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   winner;
  logic               lat_we;
  logic [IDX_W-1:0]   pick;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;

  // Scan from the farthest candidate to the nearest so the client closest after
  // last_grant is the one left standing.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [CLIENTS-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    int idx;
    rr_pick = last;
    for (int k = CLIENTS; k >= 1; k--) begin
      idx = (int'(last) + k) % CLIENTS;
      if (r[idx]) rr_pick = IDX_W'(idx);
    end
  endfunction

  always_comb begin
    pick       = rr_pick(req, last_grant);
    pick_we    = we[pick];
    pick_addr  = addr[pick*ADDR_W +: ADDR_W];
    pick_wdata = wdata[pick*DATA_W +: DATA_W];
  end

  // mem_addr/mem_wdata double as the latched operands, so they hold between ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(CLIENTS - 1);
      winner     <= '0;
      lat_we     <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner     <= pick;
            last_grant <= pick;
            lat_we     <= pick_we;
            mem_addr   <= pick_addr;
            mem_wdata  <= pick_wdata;
            mem_we     <= pick_we;
            mem_re     <= ~pick_we;
            busy       <= 1'b1;
            state      <= ACCESS;
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          if (!lat_we) rdata <= mem_rdata;
          ack   <= CLIENTS'(1) << winner;
          state <= ACK;
        end
        ACK: begin
          // Stay busy across the IDLE slot when another client is already queued.
          busy  <= |(req & ~ack);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter: a queue-based reference model
// predicts each grant, and a monitor compares memory strobes, acks and read data.
module tb_memory_arbiter;
  localparam int CLIENTS = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CLIENTS-1:0] req = '0;
  logic [CLIENTS-1:0] we  = '0;
  logic [ADDR_W-1:0]  addr_a [CLIENTS];
  logic [DATA_W-1:0]  wd_a   [CLIENTS];
  logic [CLIENTS*ADDR_W-1:0] addr;
  logic [CLIENTS*DATA_W-1:0] wdata;
  logic [CLIENTS-1:0] ack;
  logic [DATA_W-1:0]  rdata;
  logic               busy;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [DATA_W-1:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  always_comb begin
    addr  = '0;
    wdata = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      addr[k*ADDR_W +: ADDR_W]  = addr_a[k];
      wdata[k*DATA_W +: DATA_W] = wd_a[k];
    end
  end

  memory_arbiter #(.CLIENTS(CLIENTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  typedef struct {logic we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} op_t;
  typedef struct {
    int client; logic we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] rd; int acc_cyc; int ack_cyc;
  } exp_t;
  typedef struct {int client; int cyc; logic [DATA_W-1:0] rd;} log_t;

  op_t  opq [CLIENTS][$];
  exp_t sb[$];
  log_t ack_log[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int next_free = 0;
  int last_g = CLIENTS - 1;
  int grant_cyc [CLIENTS];
  int ack_cyc   [CLIENTS];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] env_mem [256];
  logic [DATA_W-1:0] ref_rdata = '0;
  logic started = 1'b0;
  logic rst_q = 1'b0;
  logic rand_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Environment memory: registered read data, garbage when no read is issued.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) env_mem[k] <= '0;
    end else if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_re ? env_mem[mem_addr] : DATA_W'($urandom);
  end

  // Reference model: one op per 4 cycles, round-robin from last winner + 1.
  always @(posedge clk) begin
    int   w;
    logic found;
    exp_t e;
    started = 1'b1;
    rst_q   = rst;
    if (rst) begin
      sb.delete();
      last_g    = CLIENTS - 1;
      next_free = cyc + 1;
      ref_rdata = '0;
      for (int k = 0; k < 256; k++) ref_mem[k] = '0;
      for (int k = 0; k < CLIENTS; k++) begin
        grant_cyc[k] = -100;
        ack_cyc[k]   = -100;
      end
    end else if (cyc >= next_free && req != '0) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= CLIENTS; k++) begin
        if (!found) begin
          w = (last_g + k) % CLIENTS;
          if (req[w]) found = 1'b1;
        end
      end
      e.client = w; e.we = we[w]; e.a = addr_a[w]; e.d = wd_a[w];
      if (we[w]) ref_mem[addr_a[w]] = wd_a[w];
      else       ref_rdata = ref_mem[addr_a[w]];
      e.rd = ref_rdata;
      e.acc_cyc = cyc + 1;
      e.ack_cyc = cyc + 3;
      sb.push_back(e);
      last_g       = w;
      next_free    = cyc + 4;
      grant_cyc[w] = cyc;
      ack_cyc[w]   = cyc + 3;
    end
    cyc++;
  end

  // Monitor: samples on the falling edge.
  exp_t m_e;
  int   m_idx;
  always @(negedge clk) begin
    if (started) begin
      if (rst_q) begin
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({mem_we, mem_re}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rdata", 32'(rdata), 0);
      end else begin
        if (sb.size() != 0 && sb[0].acc_cyc == cyc) begin
          chk("acc_mem_we", 32'(mem_we), 32'(sb[0].we));
          chk("acc_mem_re", 32'(mem_re), 32'(!sb[0].we));
          chk("acc_mem_addr", 32'(mem_addr), 32'(sb[0].a));
          chk("acc_mem_wdata", 32'(mem_wdata), 32'(sb[0].d));
          chk("acc_busy", 32'(busy), 1);
        end else begin
          chk("idle_strobes", 32'({mem_we, mem_re}), 0);
        end
        if (sb.size() != 0 && cyc > sb[0].acc_cyc && cyc <= sb[0].ack_cyc)
          chk("op_busy", 32'(busy), 1);
        if (ack != '0) begin
          chk("ack_onehot", 32'($countones(ack)), 1);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ack_unexpected: got ack=%b expected none (cycle %0d)", ack, cyc);
          end else begin
            m_e = sb.pop_front();
            m_idx = 0;
            for (int k = 0; k < CLIENTS; k++) if (ack[k]) m_idx = k;
            chk("ack_client", 32'(m_idx), 32'(m_e.client));
            chk("ack_cycle", 32'(cyc), 32'(m_e.ack_cyc));
            chk("ack_rdata", 32'(rdata), 32'(m_e.rd));
            ack_log.push_back('{client: m_idx, cyc: cyc, rd: rdata});
          end
        end else if (sb.size() != 0 && cyc == sb[0].ack_cyc) begin
          tests++;
          fails++;
          $display("FAIL ack_missing: got ack=0 expected client %0d (cycle %0d)", sb[0].client, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Requesters: hold req until ack, then drop or present the next queued op.
  initial begin
    op_t o;
    for (int k = 0; k < CLIENTS; k++) begin
      addr_a[k] = '0;
      wd_a[k]   = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < CLIENTS; i++) begin
        if (rst) begin
          req[i] = 1'b0;
        end else begin
          if (rand_mode && !req[i] && opq[i].size() == 0 && $urandom_range(3) == 0) begin
            o.we = 1'($urandom);
            o.a  = ADDR_W'(8'h40 + $urandom_range(7));
            o.d  = DATA_W'($urandom);
            opq[i].push_back(o);
          end
          if (req[i] && cyc == ack_cyc[i] + 1) begin
            if (opq[i].size() != 0) begin
              o = opq[i].pop_front();
              we[i] = o.we; addr_a[i] = o.a; wd_a[i] = o.d;
            end else begin
              req[i] = 1'b0;
            end
          end else if (req[i] && cyc == grant_cyc[i] + 1) begin
            we[i]     = 1'($urandom);
            addr_a[i] = ADDR_W'($urandom);
            wd_a[i]   = DATA_W'($urandom);
          end else if (!req[i] && opq[i].size() != 0) begin
            o = opq[i].pop_front();
            req[i] = 1'b1; we[i] = o.we; addr_a[i] = o.a; wd_a[i] = o.d;
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int c, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    op_t o;
    o.we = w; o.a = a; o.d = d;
    opq[c].push_back(o);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < CLIENTS; k++) opq[k].delete();
    sync();
    sync();
    rst = 1'b0;
  endtask

  task automatic wait_quiet();
    logic quiet;
    quiet = 1'b0;
    for (int n = 0; n < 3000 && !quiet; n++) begin
      @(posedge clk);
      #3;
      quiet = (req == '0) && (sb.size() == 0) && (cyc >= next_free);
      for (int k = 0; k < CLIENTS; k++) if (opq[k].size() != 0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL quiet_timeout: got busy traffic expected idle (cycle %0d)", cyc);
    end
  endtask

  initial begin
    int   t0;
    logic bz [17];
    logic hit;
    int   prev2;
    int   base;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single write from client 0
    sync();
    ack_log.delete();
    push_op(0, 1'b1, 8'h10, 16'h1111);
    t0 = cyc;
    wait_quiet();
    chk("w_ack_count", 32'(ack_log.size()), 1);
    if (ack_log.size() >= 1) begin
      chk("w_ack_client", 32'(ack_log[0].client), 0);
      chk("w_ack_cycle", 32'(ack_log[0].cyc - t0), 3);
    end

    // Write then read-back from client 1, back to back
    sync();
    ack_log.delete();
    push_op(1, 1'b1, 8'h20, 16'h2222);
    push_op(1, 1'b0, 8'h20, 16'h0000);
    wait_quiet();
    chk("rb_ack_count", 32'(ack_log.size()), 2);
    if (ack_log.size() >= 2) begin
      chk("rb_client", 32'(ack_log[1].client), 1);
      chk("rb_rdata", 32'(ack_log[1].rd), 32'h2222);
      chk("rb_spacing", 32'(ack_log[1].cyc - ack_log[0].cyc), 4);
    end

    // Four-way contention straight after reset
    do_reset();
    sync();
    ack_log.delete();
    for (int k = 0; k < CLIENTS; k++) push_op(k, 1'b1, ADDR_W'(8'h50 + k), DATA_W'(16'hA000 + k));
    t0 = cyc;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      bz[k] = busy;
    end
    wait_quiet();
    chk("ct_ack_count", 32'(ack_log.size()), 4);
    for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
      chk("ct_order", 32'(ack_log[k].client), 32'(k));
      chk("ct_cycle", 32'(ack_log[k].cyc - t0), 32'(3 + 4 * k));
    end
    for (int k = 1; k <= 15; k++) chk("ct_busy", 32'(bz[k]), 1);
    sync();
    sync();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Fairness between two permanently requesting clients
    sync();
    ack_log.delete();
    for (int k = 0; k < 8; k++) begin
      push_op(0, 1'($urandom), ADDR_W'(8'h60 + k), DATA_W'($urandom));
      push_op(2, 1'($urandom), ADDR_W'(8'h60 + k), DATA_W'($urandom));
    end
    wait_quiet();
    chk("fair_count", 32'(ack_log.size()), 16);
    prev2 = -1;
    for (int k = 0; k < ack_log.size(); k++) begin
      chk("fair_order", 32'(ack_log[k].client), (k % 2 == 0) ? 0 : 2);
      if (ack_log[k].client == 2) begin
        if (prev2 >= 0) chk("fair_gap_ok", 32'(ack_log[k].cyc - prev2 <= 8), 1);
        prev2 = ack_log[k].cyc;
      end
    end

    // Reset in the ACCESS cycle of client 3's write
    sync();
    ack_log.delete();
    push_op(3, 1'b1, 8'h30, 16'h3333);
    t0 = cyc;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      sync();
      if (grant_cyc[3] >= t0 && cyc == grant_cyc[3] + 1) hit = 1'b1;
    end
    chk("abort_reached_access", 32'(hit), 1);
    do_reset();
    repeat (4) sync();
    chk("abort_no_ack", 32'(ack_log.size()), 0);
    push_op(0, 1'b1, 8'h31, 16'h0101);
    push_op(3, 1'b1, 8'h32, 16'h0303);
    wait_quiet();
    chk("abort_count", 32'(ack_log.size()), 2);
    if (ack_log.size() >= 2) begin
      chk("abort_first", 32'(ack_log[0].client), 0);
      chk("abort_second", 32'(ack_log[1].client), 3);
    end

    // Random traffic from all clients
    sync();
    ack_log.delete();
    base = tests;
    rand_mode = 1'b1;
    repeat (600) sync();
    rand_mode = 1'b0;
    wait_quiet();
    chk("rand_made_progress", 32'(ack_log.size() > 50), 1);
    chk("rand_checked", 32'(tests - base > 600), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
